// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: read-owner encodings
// and statistics counter width. Optional statistics are enabled by
// defining MEMARB_STATS_EN.
package mem_port_arbiter_pkg;

    // Which requester was handed a read in the previous cycle; this steers
    // the rvalid of the returning memory data.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MM   = 2'd2
    } owner_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/mem_port_arbiter_stat_counter.sv
// Free-running event counter: increments by one on each enabled cycle,
// wraps at 2^STAT_W, cleared by the asynchronous active-low reset.
module mem_port_arbiter_stat_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    // Count enabled cycles; natural wrap on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + STAT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency word memory between instruction
// fetch (read-only) and the MM stage (load/store). MM wins each cycle unless
// fetch has been denied STARVE_MAX cycles in a row, in which case fetch is
// forced through. Read data is routed by a registered owner state.
// Optional statistics counters are built when MEMARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          mm_req,
    input  logic          mm_we,
    input  logic [AW-1:0] mm_addr,
    input  logic [DW-1:0] mm_wdata,
    output logic          mm_gnt,
    output logic          mm_rvalid,
    output logic [DW-1:0] mm_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stat_conf,
    output logic [31:0]   stat_force
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    owner_t        owner_reg;
    logic [SW-1:0] starve_reg;
    logic          force_fetch;

    // Fetch is forced only when it is actually waiting and has hit the limit.
    assign force_fetch = if_req & (starve_reg == STARVE_LIM);

    // Grants are combinational and suppressed while reset is asserted.
    assign mm_gnt = rst_n & mm_req & ~force_fetch;
    assign if_gnt = rst_n & if_req & ~mm_gnt;

    // Owner FSM: remembers which requester receives next cycle's read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_NONE;
        end else if (if_gnt) begin
            owner_reg <= OWN_IF;
        end else if (mm_gnt && !mm_we) begin
            owner_reg <= OWN_MM;
        end else begin
            owner_reg <= OWN_NONE;
        end
    end

    // Starvation counter: consecutive cycles fetch waited without a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
        end else if (!if_req || if_gnt) begin
            starve_reg <= '0;
        end else if (starve_reg != STARVE_LIM) begin
            starve_reg <= starve_reg + SW'(1);
        end
    end

    // Memory port follows the winner; idle cycles drive all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (mm_gnt) begin
            mem_addr  = mm_addr;
            mem_we    = mm_we;
            mem_wdata = mm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Read data is broadcast to both requesters; rvalid qualifies it.
    assign if_rvalid = (owner_reg == OWN_IF);
    assign mm_rvalid = (owner_reg == OWN_MM);
    assign if_rdata  = mem_rdata;
    assign mm_rdata  = mem_rdata;

`ifdef MEMARB_STATS_EN
    logic conf_event;
    logic force_event;

    // A forced fetch grant is exactly a fetch grant while MM was also asking.
    assign conf_event  = if_req & mm_req;
    assign force_event = if_gnt & mm_req;

    mem_port_arbiter_stat_counter u_stat_conf (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (conf_event),
        .count (stat_conf)
    );

    mem_port_arbiter_stat_counter u_stat_force (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (force_event),
        .count (stat_force)
    );
`else
    assign stat_conf  = '0;
    assign stat_force = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle memory.
// Statistics expectations track MEMARB_STATS_EN.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mm_req;
    logic          mm_we;
    logic [AW-1:0] mm_addr;
    logic [DW-1:0] mm_wdata;
    logic          mm_gnt;
    logic          mm_rvalid;
    logic [DW-1:0] mm_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   stat_conf;
    logic [31:0]   stat_force;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mm_req     (mm_req),
        .mm_we      (mm_we),
        .mm_addr    (mm_addr),
        .mm_wdata   (mm_wdata),
        .mm_gnt     (mm_gnt),
        .mm_rvalid  (mm_rvalid),
        .mm_rdata   (mm_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stat_conf  (stat_conf),
        .stat_force (stat_force)
    );

    // Single-port memory: read-before-write, data one cycle after address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Preload pattern: word i holds 0xA5000000 | i.
    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int STATS_ON =
`ifdef MEMARB_STATS_EN
        1;
`else
        0;
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
        rst_n = 1'b0; if_req = 1'b1; if_addr = 12'd1;
        mm_req = 1'b1; mm_we = 1'b1; mm_addr = 12'd2; mm_wdata = 32'h1234_5678;

        // Reset: requests present but nothing granted or written.
        @(negedge clk); @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_mm_gnt", 32'(mm_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rvalid", 32'({if_rvalid, mm_rvalid}), 32'd0);
        chk("rst_stat_conf", stat_conf, 32'd0);
        chk("rst_stat_force", stat_force, 32'd0);
        if_req = 1'b0; mm_req = 1'b0; mm_we = 1'b0; mm_wdata = '0;
        step(); rst_n = 1'b1;
        $display("reset checked");

        // 1: fetch only, addresses 5,6,7 back to back.
        if_req = 1'b1; if_addr = 12'd5;
        @(negedge clk);
        chk("t1_gnt5", 32'({if_gnt, mm_gnt}), 32'b10);
        chk("t1_addr5", 32'(mem_addr), 32'd5);
        for (int a = 6; a <= 7; a++) begin
            step(); if_addr = 12'(a);
            @(negedge clk);
            chk("t1_gnt", 32'({if_gnt, mm_gnt}), 32'b10);
            chk("t1_rvalid", 32'(if_rvalid), 32'd1);
            chk("t1_rdata", if_rdata, pat(a - 1));
        end
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("t1_gnt_off", 32'(if_gnt), 32'd0);
        chk("t1_rvalid7", 32'({if_rvalid, mm_rvalid}), 32'b10);
        chk("t1_rdata7", if_rdata, pat(7));
        $display("test1 fetch burst done");

        // 2: both request, MM load wins, fetch follows next cycle.
        step();
        chk("t1_rvalid_end", 32'(if_rvalid), 32'd0);
        if_req = 1'b1; if_addr = 12'h020; mm_req = 1'b1; mm_we = 1'b0; mm_addr = 12'h010;
        @(negedge clk);
        chk("t2_gnt", 32'({if_gnt, mm_gnt}), 32'b01);
        chk("t2_addr", 32'(mem_addr), 32'h010);
        step(); mm_req = 1'b0;
        @(negedge clk);
        chk("t2_if_gnt", 32'({if_gnt, mm_gnt}), 32'b10);
        chk("t2_mm_rvalid", 32'({if_rvalid, mm_rvalid}), 32'b01);
        chk("t2_mm_rdata", mm_rdata, pat(16));
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("t2_if_rvalid", 32'({if_rvalid, mm_rvalid}), 32'b10);
        chk("t2_if_rdata", if_rdata, pat(32));
        $display("test2 mm priority done");

        // 3: both held five cycles; fetch forced on the fifth.
        step();
        if_req = 1'b1; if_addr = 12'h030; mm_req = 1'b1; mm_addr = 12'h040;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_gnt", 32'({if_gnt, mm_gnt}), (c < 4) ? 32'b01 : 32'b10);
            if (c == 1) chk("t3_mm_rdata", mm_rdata, pat(64));
            step();
        end
        if_req = 1'b0; mm_req = 1'b0;
        @(negedge clk);
        chk("t3_if_rvalid", 32'({if_rvalid, mm_rvalid}), 32'b10);
        chk("t3_if_rdata", if_rdata, pat(48));
        // Conflict cycles accumulate since reset: one in test 2, five here.
        chk("t3_stat_conf", stat_conf, STATS_ON ? 32'd6 : 32'd0);
        chk("t3_stat_force", stat_force, STATS_ON ? 32'd1 : 32'd0);
        $display("test3 starvation guard done");

        // 4: store 0xDEADBEEF to word 3, then load it back.
        step();
        mm_req = 1'b1; mm_we = 1'b1; mm_addr = 12'd3; mm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_st_gnt", 32'(mm_gnt), 32'd1);
        chk("t4_st_we", 32'(mem_we), 32'd1);
        chk("t4_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t4_st_addr", 32'(mem_addr), 32'd3);
        step(); mm_we = 1'b0; mm_wdata = '0;
        @(negedge clk);
        chk("t4_ld_we", 32'(mem_we), 32'd0);
        chk("t4_st_norvalid", 32'(mm_rvalid), 32'd0);
        step(); mm_req = 1'b0;
        @(negedge clk);
        chk("t4_ld_rvalid", 32'(mm_rvalid), 32'd1);
        chk("t4_ld_rdata", mm_rdata, 32'hDEAD_BEEF);
        $display("test4 store/load done");

        // 5: reset while a fetch read is in flight drops its rvalid.
        step();
        if_req = 1'b1; if_addr = 12'd9;
        @(negedge clk);
        chk("t5_gnt", 32'(if_gnt), 32'd1);
        step();
        chk("t5_rvalid_pre", 32'(if_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_rvalid", 32'(if_rvalid), 32'd0);
        chk("t5_async_gnt", 32'({if_gnt, mm_gnt}), 32'd0);
        chk("t5_async_conf", stat_conf, 32'd0);
        chk("t5_async_force", stat_force, 32'd0);
        @(negedge clk);
        chk("t5_rst_rvalid", 32'(if_rvalid), 32'd0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t5_resume_gnt", 32'(if_gnt), 32'd1);
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("t5_resume_rvalid", 32'(if_rvalid), 32'd1);
        chk("t5_resume_rdata", if_rdata, pat(9));
        $display("test5 reset mid-read done");

        // 6: idle bus for ten cycles.
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t6_idle", 32'({mem_we, if_rvalid, mm_rvalid, if_gnt, mm_gnt}), 32'd0);
            chk("t6_addr", 32'(mem_addr), 32'd0);
            step();
        end
        $display("test6 idle done");

        // 7: dropping if_req clears the starvation count.
        if_req = 1'b1; if_addr = 12'h050; mm_req = 1'b1; mm_we = 1'b0; mm_addr = 12'h060;
        step(); step();
        if_req = 1'b0;
        @(negedge clk);
        chk("t7_mm_alone", 32'({if_gnt, mm_gnt}), 32'b01);
        step(); if_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t7_gnt", 32'({if_gnt, mm_gnt}), (c < 4) ? 32'b01 : 32'b10);
            step();
        end
        if_req = 1'b0; mm_req = 1'b0;
        @(negedge clk);
        chk("t7_if_rdata", if_rdata, pat(80));
        $display("test7 starve clear done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
